alu_op_issuer: RTL and testbench

- Initiator side of the execute-stage ALU interface: accepts operation requests over a valid/ready handshake and registers `oper`/`a`/`b` into the issue stage that drives the combinational ALU.
- Captures the ALU result into a response register and returns it with a tag over a second valid/ready handshake.
- Provides single-entry result forwarding so back-to-back dependent ops issue without bubbles.
- Sits between decode/operand-read and writeback.

---
 rtl/alu_op_issuer.sv | 67 ++++++
 tb/tb_alu_op_issuer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: registers ALU ops into an issue stage, captures results into a response stage, and forwards the newest result
// ports: clk/rst; req_* request handshake with operands, per-operand forward selects and tag;
// alu_oper/alu_a/alu_b drive the external combinational ALU, alu_result returns from it;
// rsp_* response handshake with data and tag; retired_count counts handed-off responses (wraps at 2^16)
module alu_op_issuer #(
  parameter int WIDTH = 32,
  parameter int OPER_WIDTH = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OPER_WIDTH-1:0] req_oper,
  input  logic [WIDTH-1:0]      req_a,
  input  logic [WIDTH-1:0]      req_b,
  input  logic                  req_a_fwd,
  input  logic                  req_b_fwd,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [OPER_WIDTH-1:0] alu_oper,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [15:0]           retired_count
);
  logic s0_valid, s1_free, s0_adv, accept;
  logic [TAG_WIDTH-1:0] s0_tag;
  logic [WIDTH-1:0] last_result, fwd;
  assign s1_free = !rsp_valid || rsp_ready;
  assign s0_adv = s0_valid && s1_free;
  assign req_ready = !s0_valid || s1_free;
  assign accept = req_valid && req_ready;
  // the op in S0 is always the newest accepted one, so its live result wins over the stored one
  assign fwd = s0_valid ? alu_result : last_result;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s0_valid <= 1'b0;
      alu_oper <= '0;
      alu_a <= '0;
      alu_b <= '0;
      s0_tag <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_tag <= '0;
      last_result <= '0;
      retired_count <= '0;
    end else begin
      if (accept) begin
        s0_valid <= 1'b1;
        alu_oper <= req_oper;
        alu_a <= req_a_fwd ? fwd : req_a;
        alu_b <= req_b_fwd ? fwd : req_b;
        s0_tag <= req_tag;
      end else if (s0_adv) s0_valid <= 1'b0;
      if (s0_adv) begin
        rsp_valid <= 1'b1;
        rsp_data <= alu_result;
        rsp_tag <= s0_tag;
        last_result <= alu_result;
      end else if (rsp_ready) rsp_valid <= 1'b0;
      if (rsp_valid && rsp_ready) retired_count <= retired_count + 16'd1;
    end
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed vector table plus hand sequences for forwarding, backpressure, reset and counter wrap
module tb_alu_op_issuer;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_a_fwd = 0, req_b_fwd = 0, rsp_valid, rsp_ready = 1;
  logic [3:0] req_oper = 0, req_tag = 0, alu_oper, rsp_tag;
  logic [31:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_result, rsp_data;
  logic [15:0] retired_count;
  int n_cmp = 0, n_bad = 0;

  alu_op_issuer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_oper(req_oper),
    .req_a(req_a), .req_b(req_b), .req_a_fwd(req_a_fwd), .req_b_fwd(req_b_fwd), .req_tag(req_tag),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .retired_count(retired_count));

  always #5 clk = ~clk;

  always_comb
    case (alu_oper)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = {31'b0, alu_a < alu_b};
      4'd9: alu_result = alu_a ^ alu_b;
      4'd11: alu_result = alu_a << alu_b[4:0];
      default: alu_result = 32'b0;
    endcase

  typedef struct {
    logic [3:0] oper;
    logic [31:0] a, b;
    logic af, bf;
    logic [3:0] tag;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] oper, input logic [31:0] a, input logic [31:0] b,
                       input logic af, input logic bf, input logic [3:0] tag);
    req_valid = 1; req_oper = oper; req_a = a; req_b = b; req_a_fwd = af; req_b_fwd = bf; req_tag = tag;
  endtask

  task automatic send(input vec_t v);
    int n;
    @(negedge clk);
    drive(v.oper, v.a, v.b, v.af, v.bf, v.tag);
    check("req_ready_idle", {31'b0, req_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("alu_oper", {28'b0, alu_oper}, {28'b0, v.oper});
    if (!v.af) check("alu_a", alu_a, v.a);
    if (!v.bf) check("alu_b", alu_b, v.b);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid", {31'b0, rsp_valid}, 1);
    check("rsp_data", rsp_data, v.exp);
    check("rsp_tag", {28'b0, rsp_tag}, {28'b0, v.tag});
    @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{4'd0, 32'd5, 32'd7, 1'b0, 1'b0, 4'd3, 32'd12};
    tbl[1] = '{4'd1, 32'd0, 32'd2, 1'b1, 1'b0, 4'd1, 32'd10};
    tbl[2] = '{4'd2, 32'd3, 32'd10, 1'b0, 1'b0, 4'd2, 32'd1};
    tbl[3] = '{4'd2, 32'd10, 32'd3, 1'b0, 1'b0, 4'd4, 32'd0};
    tbl[4] = '{4'd9, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 1'b0, 4'd5, 32'hF00FF00F};
    tbl[5] = '{4'd11, 32'd1, 32'd31, 1'b0, 1'b0, 4'd6, 32'h80000000};
    tbl[6] = '{4'd1, 32'd0, 32'd1, 1'b0, 1'b0, 4'd7, 32'hFFFFFFFF};
    tbl[7] = '{4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 4'd8, 32'hFFFFFFFE};
    tbl[8] = '{4'd9, 32'h0000F0F0, 32'h00000FF0, 1'b0, 1'b0, 4'd9, 32'h0000FF00};
    tbl[9] = '{4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 4'd10, 32'h0001FE00};
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    check("reset_req_ready", {31'b0, req_ready}, 1);
    check("reset_alu_a", alu_a, 0);
    check("reset_count", {16'b0, retired_count}, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) send(tbl[i]);
    check("count_after_table", {16'b0, retired_count}, 10);

    @(negedge clk);
    drive(4'd0, 32'd1, 32'd2, 1'b0, 1'b0, 4'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_ready1", {31'b0, req_ready}, 1);
    drive(4'd1, 32'hDEAD, 32'd1, 1'b1, 1'b0, 4'd2);
    @(posedge clk);
    @(negedge clk);
    check("b2b_ready2", {31'b0, req_ready}, 1);
    check("b2b_rsp1", rsp_data, 3);
    check("b2b_tag1", {28'b0, rsp_tag}, 1);
    drive(4'd11, 32'hBEEF, 32'd4, 1'b1, 1'b0, 4'd3);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("b2b_rsp2", rsp_data, 2);
    check("b2b_tag2", {28'b0, rsp_tag}, 2);
    @(negedge clk);
    check("b2b_rsp3", rsp_data, 32);
    check("b2b_tag3", {28'b0, rsp_tag}, 3);
    check("b2b_valid3", {31'b0, rsp_valid}, 1);
    @(negedge clk);
    check("b2b_drained", {31'b0, rsp_valid}, 0);

    rsp_ready = 0;
    drive(4'd0, 32'd10, 32'd1, 1'b0, 1'b0, 4'd4);
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_b", {31'b0, req_ready}, 1);
    drive(4'd0, 32'd20, 32'd2, 1'b0, 1'b0, 4'd5);
    @(posedge clk);
    @(negedge clk);
    drive(4'd0, 32'd30, 32'd3, 1'b0, 1'b0, 4'd6);
    check("bp_ready_c_blocked", {31'b0, req_ready}, 0);
    @(posedge clk);
    @(negedge clk);
    check("bp_still_blocked", {31'b0, req_ready}, 0);
    check("bp_held_data", rsp_data, 11);
    check("bp_held_tag", {28'b0, rsp_tag}, 4);
    rsp_ready = 1;
    #1;
    check("bp_ready_comb", {31'b0, req_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("bp_rsp_b", rsp_data, 22);
    check("bp_tag_b", {28'b0, rsp_tag}, 5);
    @(negedge clk);
    check("bp_rsp_c", rsp_data, 33);
    check("bp_tag_c", {28'b0, rsp_tag}, 6);
    @(negedge clk);
    check("bp_drained", {31'b0, rsp_valid}, 0);
    check("count_after_bp", {16'b0, retired_count}, 16);

    rsp_ready = 0;
    drive(4'd0, 32'd100, 32'd1, 1'b0, 1'b0, 4'd11);
    @(posedge clk);
    @(negedge clk);
    drive(4'd0, 32'd200, 32'd2, 1'b0, 1'b0, 4'd12);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("inflight_rsp", {31'b0, rsp_valid}, 1);
    check("inflight_full", {31'b0, req_ready}, 0);
    #2 rst = 1;
    #1;
    check("async_rsp_valid", {31'b0, rsp_valid}, 0);
    check("async_s0_cleared", {31'b0, req_ready}, 1);
    check("async_alu_a", alu_a, 0);
    check("async_count", {16'b0, retired_count}, 0);
    @(negedge clk);
    rst = 0;
    rsp_ready = 1;
    repeat (3) @(negedge clk);
    check("no_ghost_rsp", {31'b0, rsp_valid}, 0);
    check("no_ghost_count", {16'b0, retired_count}, 0);
    send('{4'd0, 32'hABCD, 32'd9, 1'b1, 1'b0, 4'd13, 32'd9});
    check("count_after_reset_op", {16'b0, retired_count}, 1);

    @(negedge clk);
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    check("count_max", {16'b0, retired_count}, 32'hFFFF);
    send('{4'd0, 32'd1, 32'd1, 1'b0, 1'b0, 4'd14, 32'd2});
    check("count_wrap", {16'b0, retired_count}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
